// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word fetches over req/gnt + rvalid,
// buffers returned words in a small FIFO and hands them to the decoder with
// a valid/ready handshake. Redirects flush the FIFO and drop stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        misaligned_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   resp_pc_reg, resp_pc_next;
    logic [CW-1:0] inflight_reg, inflight_next;
    logic [CW-1:0] drop_reg, drop_next;
    logic [CW-1:0] count_reg, count_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic          err_reg, err_next;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          credit_ok;
    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;

    // Credit covers both outstanding requests and buffered words, so the FIFO
    // can never overflow regardless of how fast responses come back.
    assign credit_ok = (({1'b0, inflight_reg} + {1'b0, count_reg}) < (CW+1)'(DEPTH));
    assign imem_req  = !reset && !redirect && credit_ok;
    assign imem_addr = fetch_pc_reg;
    assign grant     = imem_req && imem_gnt;
    // Responses with nothing outstanding are spurious and ignored.
    assign resp      = imem_rvalid && (inflight_reg != '0);
    assign push      = resp && (drop_reg == '0) && !redirect;

    assign instr_valid    = (count_reg != '0);
    assign pop            = instr_valid && instr_ready;
    assign instruction    = instr_valid ? instr_mem[rd_ptr_reg] : NOP;
    assign instr_pc       = instr_valid ? pc_mem[rd_ptr_reg] : 32'h0;
    assign misaligned_err = err_reg;

    // Next-state computation; redirect overrides normal fetch/response flow.
    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        resp_pc_next  = resp_pc_reg;
        inflight_next = inflight_reg + CW'(grant) - CW'(resp);
        drop_next     = drop_reg;
        count_next    = count_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        err_next      = err_reg;
        if (redirect) begin
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
            resp_pc_next  = {redirect_pc[31:2], 2'b00};
            // Every word still outstanding after this cycle is stale.
            drop_next     = inflight_reg - CW'(resp);
            count_next    = '0;
            rd_ptr_next   = wr_ptr_reg;
            if (redirect_pc[1:0] != 2'b00) begin
                err_next = 1'b1;
            end
        end else begin
            if (grant) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (resp) begin
                if (drop_reg != '0) begin
                    drop_next = drop_reg - CW'(1);
                end else begin
                    resp_pc_next = resp_pc_reg + 32'd4;
                end
            end
            count_next = count_reg + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            inflight_reg <= '0;
            drop_reg     <= '0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            resp_pc_reg  <= resp_pc_next;
            inflight_reg <= inflight_next;
            drop_reg     <= drop_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            err_reg      <= err_next;
        end
    end

    // FIFO storage: each slot captures {pc, word} when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Slot write; storage needs no reset since count gates visibility.
            always_ff @(posedge clk) begin
                if (!reset && push && (wr_ptr_reg == AW'(gi))) begin
                    pc_mem[gi]    <= resp_pc_reg;
                    instr_mem[gi] <= imem_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction-level memory and decoder-stream model
// checks every cycle's outputs, plus directed scenarios with literal values.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        misaligned_err;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .misaligned_err (misaligned_err)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    int          total = 0;
    int          bad = 0;
    req_t        q[$];
    int          cyc = 0;
    int          epoch = 0;
    int          buffered = 0;
    int          grants = 0;
    int          last_due = 0;
    logic [31:0] exp_fetch = RESET_PC;
    logic [31:0] exp_pc = RESET_PC;
    logic        err_exp = 1'b0;

    // Memory contents: a scrambled function of the word address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit rst, input bit rd, input logic [31:0] rpc,
                        input bit g, input bit rdy, input int lmin, input int lmax);
        bit   rv_real;
        bit   accepted;
        bit   req_exp;
        bit   pop_m;
        int   due;
        req_t e;
        @(negedge clk);
        reset       = rst;
        redirect    = rd;
        redirect_pc = rpc;
        imem_gnt    = g;
        instr_ready = rdy;
        rv_real     = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!rst && q.size() > 0 && q[0].due <= cyc) begin
            rv_real     = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(q[0].addr);
        end else if (!rst && q.size() == 0 && $urandom_range(7) == 0) begin
            imem_rvalid = 1'b1;   // stray response with nothing outstanding
        end
        #1;
        req_exp = !rst && !rd && ((q.size() + buffered) < DEPTH);
        check("imem_req", 32'(imem_req), 32'(req_exp));
        if (!rst) begin
            if (req_exp) check("imem_addr", imem_addr, exp_fetch);
            check("instr_valid", 32'(instr_valid), 32'(buffered != 0));
            if (buffered != 0) begin
                check("instr_pc", instr_pc, exp_pc);
                check("instruction", instruction, word_of(exp_pc));
            end else begin
                check("instr_pc_empty", instr_pc, 32'h0);
                check("instruction_empty", instruction, NOP);
            end
            check("misaligned_err", 32'(misaligned_err), 32'(err_exp));
        end
        if (rst) begin
            q.delete();
            buffered  = 0;
            exp_fetch = RESET_PC;
            exp_pc    = RESET_PC;
            err_exp   = 1'b0;
            epoch++;
            last_due  = 0;
        end else begin
            pop_m    = (buffered != 0) && rdy;
            accepted = 1'b0;
            if (rv_real) begin
                accepted = (q[0].epoch == epoch) && !rd;
                q.delete(0);
            end
            if (req_exp && g) begin
                due = cyc + $urandom_range(lmax, lmin);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                e.addr  = exp_fetch;
                e.due   = due;
                e.epoch = epoch;
                q.push_back(e);
                exp_fetch = exp_fetch + 32'd4;
                grants++;
            end
            if (rd) begin
                buffered  = 0;
                exp_pc    = {rpc[31:2], 2'b00};
                exp_fetch = {rpc[31:2], 2'b00};
                epoch++;
                if (rpc[1:0] != 2'b00) err_exp = 1'b1;
            end else begin
                if (accepted) buffered++;
                if (pop_m) begin
                    buffered--;
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        $display("cyc=%0d rst=%0b rd=%0b req=%0b gnt=%0b addr=%h rv=%0b valid=%0b rdy=%0b pc=%h ins=%h err=%0b",
                 cyc, rst, rd, imem_req, g, imem_addr, imem_rvalid, instr_valid, rdy, instr_pc, instruction, misaligned_err);
        cyc++;
    endtask

    // Run until the decoder sees a valid head or the budget expires.
    task automatic wait_valid(input string name, input logic [31:0] want_pc, input int lat);
        bit seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 1, 0, lat, lat);
            if (instr_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_seen"}, 32'(seen), 32'h1);
        if (seen) check({name, "_pc"}, instr_pc, want_pc);
    endtask

    initial begin
        logic [31:0] rpc;
        bit          rst_r, rd_r;

        // Streaming with 1-cycle memory.
        step(1, 0, 0, 1, 1, 1, 1);
        check("t1_req_in_reset", 32'(imem_req), 32'h0);
        step(0, 0, 0, 1, 1, 1, 1);
        check("t1_first_addr", imem_addr, 32'h0);
        check("t1_valid_c1", 32'(instr_valid), 32'h0);
        step(0, 0, 0, 1, 1, 1, 1);
        check("t1_valid_c2", 32'(instr_valid), 32'h0);
        step(0, 0, 0, 1, 1, 1, 1);
        check("t1_valid_c3", 32'(instr_valid), 32'h1);
        check("t1_pc0", instr_pc, 32'h0);
        check("t1_ins0", instruction, word_of(32'h0));
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 1, 1);

        // Decoder stalled: credit caps grants at DEPTH.
        step(1, 0, 0, 1, 0, 1, 1);
        grants = 0;
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 1, 1);
        check("t2_grants", 32'(grants), 32'd2);
        check("t2_req_low", 32'(imem_req), 32'h0);
        check("t2_head_pc", instr_pc, 32'h0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 1, 1);

        // Redirect with two slow responses in flight.
        step(1, 0, 0, 1, 1, 3, 3);
        step(0, 0, 0, 1, 0, 3, 3);
        step(0, 0, 0, 1, 0, 3, 3);
        step(0, 1, 32'h100, 1, 0, 3, 3);
        check("t3_req_redirect", 32'(imem_req), 32'h0);
        wait_valid("t3", 32'h100, 3);

        // Response arriving in the redirect cycle, one other word in flight.
        step(1, 0, 0, 1, 1, 2, 2);
        step(0, 0, 0, 1, 0, 2, 2);
        step(0, 0, 0, 1, 0, 2, 2);
        step(0, 1, 32'h200, 1, 0, 2, 2);
        check("t4_rvalid_on_redirect", 32'(imem_rvalid), 32'h1);
        wait_valid("t4", 32'h200, 2);

        // Grant withheld: request and address hold.
        step(1, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 1, 1);
            check("t5_req_held", 32'(imem_req), 32'h1);
            check("t5_addr_held", imem_addr, 32'h0);
        end
        step(0, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 1, 1);
        check("t5_addr_adv", imem_addr, 32'h4);

        // Misaligned redirect: aligned target, sticky error cleared by reset.
        step(1, 0, 0, 1, 1, 1, 1);
        step(0, 1, 32'h102, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 1, 1);
        check("t6_addr", imem_addr, 32'h100);
        check("t6_err", 32'(misaligned_err), 32'h1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1, 1);
        check("t6_err_sticky", 32'(misaligned_err), 32'h1);
        step(1, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1, 1, 1);
        check("t6_err_cleared", 32'(misaligned_err), 32'h0);

        // Randomized traffic with redirects, wrap-around targets and resets.
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(199) == 0);
            rd_r  = ($urandom_range(19) == 0);
            rpc   = $urandom;
            if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF8;
            step(rst_r, rd_r, rpc, $urandom_range(9) < 7, $urandom_range(9) < 7, 1, 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
